// File: rtl/i2c_bridge_pkg.sv
// Shared constants for the I2C pad bridge: register map, ID, reset values
// and STATUS bit layout, plus the Wishbone byte-lane helpers.
package i2c_bridge_pkg;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_STATUS   = 3'd1,
    REG_TIMEOUT  = 3'd2,
    REG_IRQ_MASK = 3'd3,
    REG_IRQ_PEND = 3'd4,
    REG_ID       = 3'd5
  } reg_sel_e;

  localparam logic [31:0] ID_VALUE          = 32'h1C2B_0001;
  localparam logic [31:0] TIMEOUT_RST       = 32'hFFFF_FFFF;
  localparam int          STATUS_BUSY_LSB   = 0;
  localparam int          STATUS_STUCK_LSB  = 8;
  localparam int          CTRL_LOOPBACK_BIT = 31;
  localparam int          NUM_IO            = 38;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [31:0] mask);
    return (cur & ~mask) | (wdat & mask);
  endfunction

endpackage

// File: rtl/i2c_pad_bridge_wb_if.sv
// Wishbone slave window of the I2C pad bridge.
interface i2c_pad_bridge_wb_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/i2c_pin_filter.sv
// Pad input conditioner: 2-flop synchroniser then a run-length glitch filter.
// The output only follows after FILT_LEN consecutive differing samples.
module i2c_pin_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic filt
);

  logic [1:0] sync;
  logic [3:0] cnt;

  // Idle I2C lines are high, so everything resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == 4'(FILT_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_pad_bridge_wb.sv
// Open-drain pad bridge for NUM_CH I2C masters with bus-busy / SCL-stuck
// monitoring and a Wishbone control window. Optional I2C_BRIDGE_LOOPBACK_EN.
module i2c_pad_bridge_wb
  import i2c_bridge_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int FILT_LEN  = 3,
  parameter int TIMEOUT_W = 16,
  parameter int PIN_BASE  = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  i2c_pad_bridge_wb_if.slave    wb,
  input  logic [NUM_IO-1:0]     io_in,
  output logic [NUM_IO-1:0]     io_out,
  output logic [NUM_IO-1:0]     io_oeb,
  input  logic [NUM_CH-1:0]     m_scl_o,
  input  logic [NUM_CH-1:0]     m_scl_oen,
  input  logic [NUM_CH-1:0]     m_sda_o,
  input  logic [NUM_CH-1:0]     m_sda_oen,
  output logic [NUM_CH-1:0]     m_scl_i,
  output logic [NUM_CH-1:0]     m_sda_i,
  input  logic [NUM_CH-1:0]     m_irq,
  output logic [2:0]            user_irq
);

  localparam int NEV = 2 * NUM_CH;

  logic [NUM_CH-1:0]    ctrl_en;
  logic                 loopback;
  logic [TIMEOUT_W-1:0] timeout;
  logic [NEV-1:0]       irq_mask, irq_pend, pend_set, pend_clr;
  logic [NUM_CH-1:0]    busy, stuck, stuck_ev, irq_q;
  logic                 ack, irq_agg;
  logic [31:0]          rdata, rd_mux;

  logic        access, wr;
  logic [2:0]  reg_idx;
  logic [31:0] wmask, ctrl_rd, ctrl_wv, tmo_wv, mask_wv;

  assign access  = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack;
  assign wr      = access & wb.wbs_we_i;
  assign reg_idx = wb.wbs_adr_i[4:2];
  assign wmask   = byte_mask(wb.wbs_sel_i);
  assign ctrl_rd = {loopback, {(31-NUM_CH){1'b0}}, ctrl_en};
  assign ctrl_wv = lane_merge(ctrl_rd, wb.wbs_dat_i, wmask);
  assign tmo_wv  = lane_merge(32'(timeout), wb.wbs_dat_i, wmask);
  assign mask_wv = lane_merge(32'(irq_mask), wb.wbs_dat_i, wmask);

  // ---------------- register file ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_en  <= '0;
      timeout  <= TIMEOUT_RST[TIMEOUT_W-1:0];
      irq_mask <= '0;
`ifdef I2C_BRIDGE_LOOPBACK_EN
      loopback <= 1'b0;
`endif
    end else if (wr) begin
      case (reg_idx)
        REG_CTRL: begin
          ctrl_en  <= ctrl_wv[NUM_CH-1:0];
`ifdef I2C_BRIDGE_LOOPBACK_EN
          loopback <= ctrl_wv[CTRL_LOOPBACK_BIT];
`endif
        end
        REG_TIMEOUT:  timeout  <= tmo_wv[TIMEOUT_W-1:0];
        REG_IRQ_MASK: irq_mask <= mask_wv[NEV-1:0];
        default: ;
      endcase
    end
  end

`ifndef I2C_BRIDGE_LOOPBACK_EN
  assign loopback = 1'b0;
`endif

  // A new event in the same cycle as its W1C clear survives.
  assign pend_clr = (wr && reg_idx == REG_IRQ_PEND) ? (wb.wbs_dat_i[NEV-1:0] & wmask[NEV-1:0]) : '0;
  assign pend_set = {stuck_ev, m_irq & ~irq_q};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_q    <= '0;
      irq_pend <= '0;
      irq_agg  <= 1'b0;
    end else begin
      irq_q    <= m_irq;
      irq_pend <= (irq_pend & ~pend_clr) | pend_set;
      irq_agg  <= |(irq_pend & irq_mask);
    end
  end

  assign user_irq = {2'b00, irq_agg};

  // ---------------- Wishbone read path ----------------
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_CTRL:     rd_mux = ctrl_rd;
      REG_STATUS: begin
        rd_mux[STATUS_BUSY_LSB  +: NUM_CH] = busy;
        rd_mux[STATUS_STUCK_LSB +: NUM_CH] = stuck;
      end
      REG_TIMEOUT:  rd_mux = 32'(timeout);
      REG_IRQ_MASK: rd_mux = 32'(irq_mask);
      REG_IRQ_PEND: rd_mux = 32'(irq_pend);
      REG_ID:       rd_mux = ID_VALUE;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= access;
      rdata <= (access & ~wb.wbs_we_i) ? rd_mux : 32'h0;
    end
  end

  assign wb.wbs_ack_o = ack;
  assign wb.wbs_dat_o = rdata;

  // ---------------- pads ----------------
  logic [NEV-1:0]    pad_filt;
  logic [NUM_CH-1:0] scl_drv, sda_drv, scl_line, sda_line;

  assign scl_drv = m_scl_oen & ~m_scl_o & ctrl_en;
  assign sda_drv = m_sda_oen & ~m_sda_o & ctrl_en;

  for (genvar p = 0; p < NEV; p++) begin : g_filt
    i2c_pin_filter #(.FILT_LEN(FILT_LEN)) u_filt (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .pin  (io_in[PIN_BASE+p]),
      .filt (pad_filt[p])
    );
  end

  // Output enable is combinational from ctrl_en so reset releases pads at once.
  always_comb begin
    io_oeb = '1;
    if (!loopback) begin
      for (int k = 0; k < NUM_CH; k++) begin
        io_oeb[PIN_BASE+2*k]   = ~scl_drv[k];
        io_oeb[PIN_BASE+2*k+1] = ~sda_drv[k];
      end
    end
  end

  assign io_out  = '0;
  assign m_scl_i = scl_line;
  assign m_sda_i = sda_line;

`ifdef I2C_BRIDGE_LOOPBACK_EN
  logic lb_scl, lb_sda;
  assign lb_scl = ~|scl_drv;
  assign lb_sda = ~|sda_drv;
`endif

  // ---------------- per-channel monitor ----------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic                 scl_q, sda_q, busy_r, stuck_r, run, hit;
    logic [TIMEOUT_W-1:0] cnt;

`ifdef I2C_BRIDGE_LOOPBACK_EN
    assign scl_line[k] = ~ctrl_en[k] | (loopback ? lb_scl : pad_filt[2*k]);
    assign sda_line[k] = ~ctrl_en[k] | (loopback ? lb_sda : pad_filt[2*k+1]);
`else
    assign scl_line[k] = ~ctrl_en[k] | pad_filt[2*k];
    assign sda_line[k] = ~ctrl_en[k] | pad_filt[2*k+1];
`endif

    // Only count low time the own master is not responsible for.
    assign run         = ~scl_line[k] & ~scl_drv[k] & (timeout != '0);
    assign hit         = run & (cnt >= timeout);
    assign stuck_ev[k] = hit & ~stuck_r;
    assign busy[k]     = busy_r;
    assign stuck[k]    = stuck_r;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        scl_q   <= 1'b1;
        sda_q   <= 1'b1;
        busy_r  <= 1'b0;
        stuck_r <= 1'b0;
        cnt     <= '0;
      end else begin
        scl_q <= scl_line[k];
        sda_q <= sda_line[k];
        if (!ctrl_en[k])
          busy_r <= 1'b0;
        else if (scl_line[k] && scl_q && sda_q && !sda_line[k])
          busy_r <= 1'b1;
        else if (scl_line[k] && scl_q && !sda_q && sda_line[k])
          busy_r <= 1'b0;

        if (!run)                cnt <= '0;
        else if (cnt < timeout)  cnt <= cnt + TIMEOUT_W'(1);

        if (scl_line[k] || timeout == '0) stuck_r <= 1'b0;
        else if (hit)                     stuck_r <= 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{io_in, wb.wbs_adr_i, ctrl_wv, tmo_wv, mask_wv, wmask};

endmodule

// File: tb/tb_i2c_pad_bridge_wb.sv
// Scoreboard bench for i2c_pad_bridge_wb: WB responses are checked by a
// monitor against a register-level model; pad behaviour is checked inline.
module tb_i2c_pad_bridge_wb;
  localparam int NUM_CH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_pad_bridge_wb_if wb();

  logic [37:0] pad_ext, io_in, io_out, io_oeb;
  logic [NUM_CH-1:0] m_scl_o, m_scl_oen, m_sda_o, m_sda_oen, m_scl_i, m_sda_i;
  logic [NUM_CH-1:0] m_irq, irq_next;
  logic [2:0] user_irq;

  // Pull-up pad: low if anyone drives it or the external world pulls it.
  assign io_in = pad_ext & io_oeb;

  i2c_pad_bridge_wb dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .m_scl_o(m_scl_o), .m_scl_oen(m_scl_oen), .m_sda_o(m_sda_o), .m_sda_oen(m_sda_oen),
    .m_scl_i(m_scl_i), .m_sda_i(m_sda_i), .m_irq(m_irq), .user_irq(user_irq)
  );

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

`ifdef I2C_BRIDGE_LOOPBACK_EN
  localparam logic [31:0] CTRL_VALID = 32'h8000_0003;
`else
  localparam logic [31:0] CTRL_VALID = 32'h0000_0003;
`endif

  // Reference register state
  logic [31:0] m_ctrl, m_tmo, m_mask, m_pend, exp_status;

  task automatic model_reset();
    m_ctrl = 0; m_tmo = 32'h0000_FFFF; m_mask = 0; m_pend = 0; exp_status = 0;
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    case (adr[4:2])
      3'd0: return m_ctrl;
      3'd1: return exp_status;
      3'd2: return m_tmo;
      3'd3: return m_mask;
      3'd4: return m_pend;
      3'd5: return 32'h1C2B_0001;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    case (adr[4:2])
      3'd0: m_ctrl = lanes(m_ctrl, dat, sel) & CTRL_VALID;
      3'd2: m_tmo  = lanes(m_tmo, dat, sel) & 32'h0000_FFFF;
      3'd3: m_mask = lanes(m_mask, dat, sel) & 32'h0000_000F;
      3'd4: m_pend = m_pend & ~lanes(32'h0, dat, sel);
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
    bit got;
    @(posedge clk); #1;
    wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr; wb.wbs_dat_i = dat; wb.wbs_sel_i = sel;
    m_irq = irq_next;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) got = 1;
    end
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_ack_timeout adr=%0h", adr);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    exp_q.push_back(32'h0);
    xfer(1'b1, adr, dat, sel);
    model_write(adr, dat, sel);
  endtask

  task automatic wb_read(input logic [31:0] adr);
    exp_q.push_back(model_read(adr));
    xfer(1'b0, adr, 32'h0, 4'h0);
  endtask

  // Monitor: every ack consumes one expected word; idle data must be 0.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb.wbs_ack_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected_ack dat=%0h", wb.wbs_dat_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if (wb.wbs_dat_o !== mon_exp) begin
            errors++;
            $display("FAIL wb_rdata adr=%0h got=%0h exp=%0h", wb.wbs_adr_i, wb.wbs_dat_o, mon_exp);
          end
        end
      end else if (wb.wbs_dat_o !== 32'h0) begin
        checks++; errors++;
        $display("FAIL wb_idle_dat got=%0h exp=0", wb.wbs_dat_o);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr;
    int lat, waited;
    bit low_seen, got;

    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    pad_ext = '1; m_scl_o = 0; m_scl_oen = 0; m_sda_o = 0; m_sda_oen = 0;
    m_irq = 0; irq_next = 0;
    model_reset();
    rst = 1;
    repeat (3) @(posedge clk); #1;
    chk("reset_oeb", io_oeb, {38{1'b1}});
    chk("reset_out", io_out, 0);
    chk("reset_scl_i", m_scl_i, 2'b11);
    chk("reset_sda_i", m_sda_i, 2'b11);
    chk("reset_user_irq", user_irq, 0);
    chk("reset_ack", wb.wbs_ack_o, 0);
    rst = 0;

    // Register map basics
    wb_read(32'h14); wb_read(32'h00); wb_read(32'h04); wb_read(32'h08);
    wb_read(32'h0C); wb_read(32'h10);
    wb_write(32'h18, $urandom, 4'hF); wb_read(32'h18);
    wb_write(32'h14, $urandom, 4'hF); wb_read(32'h14);

    // Randomised register traffic with idle pads
    for (int i = 0; i < 60; i++) begin
      adr = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 1) == 1) wb_write(adr, $urandom, 4'($urandom));
      else                           wb_read(adr);
    end
    wb_write(32'h00, 32'h1, 4'hF);
    wb_write(32'h0C, 32'h0, 4'hF);
    wb_read(32'h00);

    // Open-drain pad drive
    m_scl_oen[0] = 1; m_scl_o[0] = 0; #1;
    chk("pad_drive_low_oeb", io_oeb[8], 0);
    chk("pad_out_zero", io_out, 0);
    m_scl_o[0] = 1; #1;
    chk("pad_drive_high_released", io_oeb[8], 1);
    m_scl_oen[1] = 1; m_scl_o[1] = 0; #1;
    chk("pad_disabled_ch_released", io_oeb[11:10], 2'b11);
    chk("disabled_ch_scl_i", m_scl_i[1], 1);
    m_scl_oen = 0; m_scl_o = 0;

    // Glitch rejection: two low samples
    low_seen = 0;
    @(posedge clk); #1 pad_ext[9] = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) pad_ext[9] = 1;
      if (!m_sda_i[0]) low_seen = 1;
    end
    chk("glitch_rejected", low_seen, 0);

    // Six low samples: filtered edge appears 5 cycles after the pad
    lat = 0;
    @(posedge clk); #1 pad_ext[9] = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (!m_sda_i[0] && lat == 0) lat = i;
      if (i == 6) pad_ext[9] = 1;
    end
    chk("sda_filter_latency", lat, 5);
    repeat (8) @(posedge clk); #1;
    chk("sda_restored", m_sda_i[0], 1);
    wb_read(32'h04);

    // START / STOP detection
    pad_ext[9] = 0;
    repeat (8) @(posedge clk);
    exp_status = 32'h1;
    wb_read(32'h04);
    pad_ext[9] = 1;
    repeat (8) @(posedge clk);
    exp_status = 32'h0;
    wb_read(32'h04);

    // SCL stuck low
    wb_write(32'h08, 32'd20, 4'hF);
    wb_write(32'h0C, 32'h4, 4'hF);
    @(posedge clk); #1 pad_ext[8] = 0;
    got = 0; waited = 0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(posedge clk); #1;
      if (user_irq[0]) begin got = 1; waited = i; end
    end
    chk("stuck_irq_raised", got, 1);
    chk("stuck_latency_in_range", (waited >= 22 && waited <= 32), 1);
    exp_status = 32'h100;
    m_pend |= 32'h4;
    wb_read(32'h04);
    wb_read(32'h10);
    wb_write(32'h10, 32'h4, 4'hF);
    wb_read(32'h10);
    repeat (40) @(posedge clk);
    wb_read(32'h10);
    wb_read(32'h04);
    #1 chk("stuck_irq_cleared", user_irq[0], 0);
    pad_ext[8] = 1;
    repeat (10) @(posedge clk);
    exp_status = 32'h0;
    wb_read(32'h04);

    // Master interrupt edges and set-beats-clear
    irq_next = 2'b10; m_irq = 2'b10;
    repeat (2) @(posedge clk);
    m_pend |= 32'h2;
    wb_read(32'h10);
    irq_next = 2'b00; m_irq = 2'b00;
    wb_write(32'h10, 32'h2, 4'hF);
    wb_read(32'h10);
    irq_next = 2'b10;
    wb_write(32'h10, 32'h2, 4'hF);
    m_pend |= 32'h2;
    wb_read(32'h10);
    irq_next = 2'b00; m_irq = 2'b00;

    // Reset in the middle of a transfer releases every pad
    wb_write(32'h00, 32'h3, 4'hF);
    m_scl_oen = '1; m_scl_o = '0; m_sda_oen = '1; m_sda_o = '0; #1;
    chk("all_driven_low", io_oeb[11:8], 4'b0000);
    @(posedge clk); #1;
    wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = 0; wb.wbs_adr_i = 32'h14;
    #2 rst = 1;
    #1;
    chk("midreset_oeb", io_oeb, {38{1'b1}});
    chk("midreset_ack", wb.wbs_ack_o, 0);
    chk("midreset_scl_i", m_scl_i, 2'b11);
    wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0;
    m_scl_oen = 0; m_sda_oen = 0;
    model_reset();
    repeat (2) @(posedge clk); #1 rst = 0;
    wb_read(32'h00);
    wb_read(32'h08);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
